// File: rtl/axis_rx_frame_buffer_pkg.sv
// Shared types and constants for the AXI-Stream RX frame buffer.
package axis_rx_frame_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } rx_state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/axis_rx_frame_buffer_if.sv
// AXI-Stream byte channel. The frame buffer owns a slave port for input and a master port for output.
interface axis_rx_frame_buffer_if
    import axis_rx_frame_buffer_pkg::*;
#(
    parameter int DATA_W = BYTE_W
);

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tuser;
    logic              trdy;

    modport master (output tdata, output tvalid, output tlast, output tuser, input trdy);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output trdy);

endinterface

// File: rtl/axis_rx_frame_buffer_sdp_ram.sv
// Simple dual-port RAM with one write port and one synchronous, enabled read port.
module sdp_ram #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // rdata_o holds its value while re_i is low, so it can act as a pipeline stage.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/axis_rx_frame_buffer.sv
// Store-and-forward AXI-Stream byte-frame receiver. It buffers whole frames and forwards only
// complete, error-free ones. Errored, oversized or non-fitting frames are discarded, never stalled.
module axis_rx_frame_buffer
    import axis_rx_frame_buffer_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int DEPTH          = 4096,
    parameter int MAX_FRAME      = 1518,
    parameter int CNT_W          = 16
) (
    input  logic                   s_aclk,
    input  logic                   s_sresetn,
    axis_rx_frame_buffer_if.slave  s_axis,
    axis_rx_frame_buffer_if.master m_axis,
    output logic                   frame_good,
    output logic                   frame_drop,
    output logic [CNT_W-1:0]       good_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int BCNT_W  = $clog2(MAX_FRAME + 1);
    localparam int ENTRY_W = AXI_DATA_WIDTH + 1;

    rx_state_t                 state_q;
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          wr_commit_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [BCNT_W-1:0]         byte_cnt_q;
    logic                      s_trdy_q;
    logic                      frame_good_q;
    logic                      frame_drop_q;
    logic [CNT_W-1:0]          good_cnt_q;
    logic [CNT_W-1:0]          drop_cnt_q;
    logic                      ram_vld_q;
    logic                      m_tvalid_q;
    logic                      m_tlast_q;
    logic [AXI_DATA_WIDTH-1:0] m_tdata_q;

    logic                      accept;
    logic                      full;
    logic                      empty;
    logic                      abort;
    logic                      ram_we;
    logic                      ram_re;
    logic                      out_load;
    logic [PTR_W-1:0]          wr_ptr_inc;
    logic [ENTRY_W-1:0]        ram_rdata;

    assign accept     = s_axis.tvalid & s_trdy_q;
    assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);
    assign full       = (wr_ptr_inc ^ rd_ptr_q) == {1'b1, {ADDR_W{1'b0}}};
    assign empty      = (rd_ptr_q == wr_commit_q);
    assign abort      = full | (byte_cnt_q == BCNT_W'(MAX_FRAME));
    assign ram_we     = accept & (state_q != DROP) & ~abort;

    // The RAM output register is the first read stage and the m_axis register is the second.
    assign out_load   = ram_vld_q & (~m_tvalid_q | m_axis.trdy);
    assign ram_re     = ~empty & (~ram_vld_q | out_load);

    sdp_ram #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (s_aclk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i ({s_axis.tlast, s_axis.tdata}),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge s_aclk or negedge s_sresetn) begin
        if (!s_sresetn) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            byte_cnt_q   <= '0;
            s_trdy_q     <= 1'b0;
            frame_good_q <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            s_trdy_q     <= 1'b1;
            frame_good_q <= 1'b0;
            frame_drop_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    IDLE, RECV: begin
                        // Overflow on the last beat still finishes the frame as a drop.
                        if (abort) begin
                            wr_ptr_q   <= wr_commit_q;
                            byte_cnt_q <= '0;
                            if (s_axis.tlast) begin
                                frame_drop_q <= 1'b1;
                                state_q      <= IDLE;
                            end else begin
                                state_q      <= DROP;
                            end
                        end else if (s_axis.tlast) begin
                            byte_cnt_q <= '0;
                            state_q    <= IDLE;
                            if (s_axis.tuser) begin
                                wr_ptr_q     <= wr_commit_q;
                                frame_drop_q <= 1'b1;
                            end else begin
                                wr_ptr_q     <= wr_ptr_inc;
                                wr_commit_q  <= wr_ptr_inc;
                                frame_good_q <= 1'b1;
                            end
                        end else begin
                            wr_ptr_q   <= wr_ptr_inc;
                            byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                            state_q    <= RECV;
                        end
                    end
                    DROP: begin
                        if (s_axis.tlast) begin
                            frame_drop_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge s_aclk or negedge s_sresetn) begin
        if (!s_sresetn) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (frame_good_q && (good_cnt_q != '1)) begin
                good_cnt_q <= good_cnt_q + CNT_W'(1);
            end
            if (frame_drop_q && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge s_aclk or negedge s_sresetn) begin
        if (!s_sresetn) begin
            rd_ptr_q   <= '0;
            ram_vld_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
        end else begin
            if (ram_re) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                ram_vld_q <= 1'b1;
            end else if (out_load) begin
                ram_vld_q <= 1'b0;
            end
            if (out_load) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= ram_rdata[AXI_DATA_WIDTH-1:0];
                m_tlast_q  <= ram_rdata[AXI_DATA_WIDTH];
            end else if (m_axis.trdy) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign s_axis.trdy   = s_trdy_q;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign m_axis.tuser  = 1'b0;
    assign frame_good    = frame_good_q;
    assign frame_drop    = frame_drop_q;
    assign good_cnt      = good_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_axis_rx_frame_buffer.sv
// Randomized bench for the RX frame buffer. It drives a full-size instance and a 64-entry
// instance, and compares their output against a frame-level queue model.
module tb_axis_rx_frame_buffer;

    localparam int BIG_MAX   = 1518;
    localparam int SMALL_MAX = 60;

    logic clock;
    logic sResetn;
    bit   sel;
    int   trdyMode;
    logic inTvalid, inTlast, inTuser;
    logic [7:0] inTdata;
    logic outTrdy;

    logic        goodMain, dropMain, goodSm, dropSm;
    logic [15:0] goodCntMain, dropCntMain, goodCntSm, dropCntSm;
    logic        obsValid, obsLast;
    logic [7:0]  obsData;

    logic [8:0] expQ[$];
    int expGood[2];
    int expDrop[2];
    int goodPulses[2];
    int dropPulses[2];
    int checkCount = 0;
    int errorCount = 0;
    bit stalled;
    logic [8:0] heldBeat;
    logic [8:0] expBeat;

    axis_rx_frame_buffer_if sIf ();
    axis_rx_frame_buffer_if mIf ();
    axis_rx_frame_buffer_if sSm ();
    axis_rx_frame_buffer_if mSm ();

    assign sIf.tdata  = inTdata;
    assign sIf.tlast  = inTlast;
    assign sIf.tuser  = inTuser;
    assign sIf.tvalid = inTvalid & ~sel;
    assign sSm.tdata  = inTdata;
    assign sSm.tlast  = inTlast;
    assign sSm.tuser  = inTuser;
    assign sSm.tvalid = inTvalid & sel;
    assign mIf.trdy   = outTrdy & ~sel;
    assign mSm.trdy   = outTrdy & sel;

    assign obsValid = sel ? mSm.tvalid : mIf.tvalid;
    assign obsLast  = sel ? mSm.tlast  : mIf.tlast;
    assign obsData  = sel ? mSm.tdata  : mIf.tdata;

    axis_rx_frame_buffer dut (
        .s_aclk     (clock),
        .s_sresetn  (sResetn),
        .s_axis     (sIf),
        .m_axis     (mIf),
        .frame_good (goodMain),
        .frame_drop (dropMain),
        .good_cnt   (goodCntMain),
        .drop_cnt   (dropCntMain)
    );

    axis_rx_frame_buffer #(
        .DEPTH     (64),
        .MAX_FRAME (SMALL_MAX)
    ) dutSmall (
        .s_aclk     (clock),
        .s_sresetn  (sResetn),
        .s_axis     (sSm),
        .m_axis     (mSm),
        .frame_good (goodSm),
        .frame_drop (dropSm),
        .good_cnt   (goodCntSm),
        .drop_cnt   (dropCntSm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // The output monitor chooses the downstream ready level for the next edge, then scores the
    // beat that this edge transfers and checks that a stalled beat is held.
    always @(negedge clock) begin
        if (!sResetn) begin
            stalled       = 1'b0;
            goodPulses[0] = 0;
            goodPulses[1] = 0;
            dropPulses[0] = 0;
            dropPulses[1] = 0;
        end else begin
            case (trdyMode)
                0:       outTrdy = 1'b1;
                1:       outTrdy = 1'($urandom_range(0, 1));
                default: outTrdy = 1'b0;
            endcase
            if (stalled) begin
                checkOutput("stall_valid", 32'(obsValid), 32'd1);
                checkOutput("stall_hold", 32'({obsLast, obsData}), 32'(heldBeat));
            end
            if (obsValid && outTrdy) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(obsValid), 32'd0);
                end else begin
                    expBeat = expQ.pop_front();
                    checkOutput("beat", 32'({obsLast, obsData}), 32'(expBeat));
                end
            end
            stalled  = obsValid && !outTrdy;
            heldBeat = {obsLast, obsData};
            if (goodMain) goodPulses[0]++;
            if (dropMain) dropPulses[0]++;
            if (goodSm)   goodPulses[1]++;
            if (dropSm)   dropPulses[1]++;
        end
    end

    // This task sends one frame, with optional idle gaps, to the selected instance. A frame is
    // expected on the output only if it is error-free, within the size limit and known to fit.
    task automatic applyStimulus(input int len, input bit err, input bit incPattern,
                                 input int validPct, input bit fits);
        logic [8:0] beats[$];
        logic [7:0] data;
        bit last;
        int maxF;
        maxF = sel ? SMALL_MAX : BIG_MAX;
        for (int i = 0; i < len; i++) begin
            data = incPattern ? 8'(i + 1) : 8'($urandom);
            last = (i == len - 1);
            while ($urandom_range(1, 100) > validPct) begin
                inTvalid = 1'b0;
                @(posedge clock); #1;
            end
            inTvalid = 1'b1;
            inTdata  = data;
            inTlast  = last;
            inTuser  = last ? err : 1'($urandom);
            @(posedge clock); #1;
            beats.push_back({last, data});
        end
        inTvalid = 1'b0;
        inTlast  = 1'b0;
        inTuser  = 1'b0;
        if (!err && len <= maxF && fits) begin
            foreach (beats[k]) expQ.push_back(beats[k]);
            expGood[sel]++;
        end else begin
            expDrop[sel]++;
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while ((expQ.size() != 0 || obsValid) && n < maxCycles) begin
            @(posedge clock); #1;
            n++;
        end
        checkOutput("drain_done", 32'(expQ.size() != 0 || obsValid), 32'd0);
    endtask

    task automatic checkCounters(input string tag);
        repeat (3) @(posedge clock);
        #1;
        checkOutput({tag, "_good_cnt"}, 32'(sel ? goodCntSm : goodCntMain), 32'(expGood[sel]));
        checkOutput({tag, "_drop_cnt"}, 32'(sel ? dropCntSm : dropCntMain), 32'(expDrop[sel]));
        checkOutput({tag, "_good_pulses"}, 32'(goodPulses[sel]), 32'(expGood[sel]));
        checkOutput({tag, "_drop_pulses"}, 32'(dropPulses[sel]), 32'(expDrop[sel]));
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sResetn  = 1'b0;
        sel      = 1'b0;
        trdyMode = 0;
        outTrdy  = 1'b0;
        inTvalid = 1'b0;
        inTlast  = 1'b0;
        inTuser  = 1'b0;
        inTdata  = 8'h00;
        expGood  = '{0, 0};
        expDrop  = '{0, 0};

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_s_trdy", 32'(sIf.trdy), 32'd0);
        checkOutput("rst_m_tvalid", 32'(mIf.tvalid), 32'd0);
        checkOutput("rst_good_cnt", 32'(goodCntMain), 32'd0);
        checkOutput("rst_drop_cnt", 32'(dropCntMain), 32'd0);
        @(negedge clock);
        sResetn = 1'b1;
        @(posedge clock); #1;
        checkOutput("s_trdy_after_rst", 32'(sIf.trdy), 32'd1);

        $display("[TB] test 1: 64 byte good frame and output latency");
        applyStimulus(64, 1'b0, 1'b1, 100, 1'b1);
        checkOutput("t1_good_pulse", 32'(goodMain), 32'd1);
        checkOutput("t1_valid_e0", 32'(mIf.tvalid), 32'd0);
        @(posedge clock); #1;
        checkOutput("t1_valid_e1", 32'(mIf.tvalid), 32'd0);
        checkOutput("t1_pulse_width", 32'(goodMain), 32'd0);
        @(posedge clock); #1;
        checkOutput("t1_valid_e2", 32'(mIf.tvalid), 32'd1);
        checkOutput("t1_first_byte", 32'(mIf.tdata), 32'h01);
        waitDrain(500);
        checkCounters("t1");

        $display("[TB] test 2: errored frame then good frame");
        applyStimulus(20, 1'b1, 1'b0, 100, 1'b1);
        applyStimulus(30, 1'b0, 1'b0, 100, 1'b1);
        waitDrain(500);
        checkCounters("t2");

        $display("[TB] test 3: frame size limit");
        applyStimulus(1519, 1'b0, 1'b0, 100, 1'b1);
        applyStimulus(1518, 1'b0, 1'b0, 100, 1'b1);
        applyStimulus(60, 1'b0, 1'b0, 100, 1'b1);
        waitDrain(5000);
        checkCounters("t3");

        $display("[TB] test 4: overflow on a 64 entry buffer");
        sel      = 1'b1;
        trdyMode = 2;
        applyStimulus(40, 1'b0, 1'b1, 100, 1'b1);
        applyStimulus(40, 1'b0, 1'b0, 100, 1'b0);
        checkCounters("t4_stalled");
        trdyMode = 0;
        waitDrain(500);
        applyStimulus(50, 1'b0, 1'b0, 100, 1'b1);
        waitDrain(500);
        checkCounters("t4");
        sel = 1'b0;

        $display("[TB] test 5: random frames with random backpressure");
        trdyMode = 1;
        for (int f = 0; f < 100; f++) begin
            int len;
            bit err;
            len = (f % 10 == 0) ? int'($urandom_range(1, BIG_MAX)) : int'($urandom_range(1, 200));
            if (f == 3) len = BIG_MAX;
            if (f == 5) len = 1;
            err = ($urandom_range(0, 7) == 0);
            applyStimulus(len, err, 1'b0, 75, 1'b1);
            if (f % 2 == 1) waitDrain(20000);
        end
        waitDrain(20000);
        checkCounters("t5");

        $display("[TB] test 6: asynchronous reset mid-frame");
        trdyMode = 2;
        applyStimulus(8, 1'b0, 1'b0, 100, 1'b1);
        repeat (4) @(posedge clock);
        #1;
        checkOutput("t6_pre_valid", 32'(mIf.tvalid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            inTvalid = 1'b1;
            inTlast  = 1'b0;
            inTdata  = 8'($urandom);
            @(posedge clock); #1;
        end
        sResetn = 1'b0;
        #1;
        checkOutput("t6_s_trdy", 32'(sIf.trdy), 32'd0);
        checkOutput("t6_m_tvalid", 32'(mIf.tvalid), 32'd0);
        checkOutput("t6_m_tdata", 32'(mIf.tdata), 32'd0);
        checkOutput("t6_m_tlast", 32'(mIf.tlast), 32'd0);
        checkOutput("t6_good_cnt", 32'(goodCntMain), 32'd0);
        checkOutput("t6_drop_cnt", 32'(dropCntMain), 32'd0);
        checkOutput("t6_frame_good", 32'(goodMain), 32'd0);
        checkOutput("t6_frame_drop", 32'(dropMain), 32'd0);
        inTvalid = 1'b0;
        expQ.delete();
        expGood  = '{0, 0};
        expDrop  = '{0, 0};
        trdyMode = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        sResetn = 1'b1;
        @(posedge clock); #1;
        checkOutput("t6_s_trdy_release", 32'(sIf.trdy), 32'd1);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("t6_empty", 32'(mIf.tvalid), 32'd0);
        applyStimulus(50, 1'b0, 1'b0, 100, 1'b1);
        waitDrain(500);
        checkCounters("t6");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
